// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline control for the 16-bit, 8-register, five-stage core.
//               Decides stall/flush per pipeline register each cycle, selects
//               Execute operand forwarding, freezes the whole pipeline while
//               data memory is busy, and traps a memory timeout into a sticky
//               error state that only reset clears.
// Ports       : clk, rst                      clock / async active-high reset
//               rs*_d, uses_rs*_d             Decode source registers + usage
//               rs*_e                         Execute source registers
//               wb_*, write_reg_*             destination / write enable per stage
//               load_ex, load_mem             load in Execute / Memory
//               branch_taken_ex, jump_d       control-flow redirects
//               mem_busy                      data memory not ready
//               stall_f/d/e/m, flush_d/e      pipeline register control
//               fwd_a, fwd_b                  00 regfile, 01 Mem ALU, 10 Writeback
//               state, mem_error              00 RUN, 01 MEM_WAIT, 10 ERROR
//               stall_cycles, flush_events    saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       rs1_d,
    input  logic [2:0]       rs2_d,
    input  logic             uses_rs1_d,
    input  logic             uses_rs2_d,
    input  logic [2:0]       rs1_e,
    input  logic [2:0]       rs2_e,
    input  logic [2:0]       wb_ex,
    input  logic [2:0]       wb_mem,
    input  logic [2:0]       wb_wb,
    input  logic             write_reg_ex,
    input  logic             write_reg_mem,
    input  logic             write_reg_wb,
    input  logic             load_ex,
    input  logic             load_mem,
    input  logic             branch_taken_ex,
    input  logic             jump_d,
    input  logic             mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    // wait_cnt counts busy cycles already spent; the RUN cycle that first
    // saw mem_busy counts as 1, so TIMEOUT-1 in MEM_WAIT is the last one.
    localparam logic [7:0]       c_WAIT_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [7:0]       r_waitCnt;
    logic             r_memError;
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushEvents;

    logic             w_loadUse;
    logic             w_holdAll;
    logic             w_stallF;
    logic             w_stallD;
    logic             w_stallE;
    logic             w_stallM;
    logic             w_flushD;
    logic             w_flushE;
    logic [1:0]       w_fwdA;
    logic [1:0]       w_fwdB;

    // Memory-stage ALU result wins over Writeback; a load in Memory has no
    // data yet, so it must fall through to the older Writeback value.
    function automatic logic [1:0] fwdSel(input logic [2:0] src,
                                          input logic       wrMem,
                                          input logic [2:0] dstMem,
                                          input logic       ldMem,
                                          input logic       wrWb,
                                          input logic [2:0] dstWb);
        logic [1:0] sel;
        sel = 2'b00;
        if (wrMem && (dstMem != 3'd0) && (dstMem == src) && !ldMem) begin
            sel = 2'b01;
        end else if (wrWb && (dstWb != 3'd0) && (dstWb == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        w_loadUse = load_ex && write_reg_ex && (wb_ex != 3'd0) &&
                    ((uses_rs1_d && (rs1_d == wb_ex)) ||
                     (uses_rs2_d && (rs2_d == wb_ex)));
        // Error freezes everything; otherwise a busy memory freezes the
        // pipeline in either RUN or MEM_WAIT. MEM_WAIT without busy falls
        // through to the RUN rules in the same cycle (zero-cycle release).
        w_holdAll = (r_state == ST_ERROR) || mem_busy;

        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        w_fwdA   = 2'b00;
        w_fwdB   = 2'b00;

        if (!rst) begin
            w_fwdA = fwdSel(rs1_e, write_reg_mem, wb_mem, load_mem, write_reg_wb, wb_wb);
            w_fwdB = fwdSel(rs2_e, write_reg_mem, wb_mem, load_mem, write_reg_wb, wb_wb);

            if (w_holdAll) begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_stallE = 1'b1;
                w_stallM = 1'b1;
            end else if (branch_taken_ex) begin
                // Decode holds a wrong-path instruction, so its load-use or
                // jump is irrelevant.
                w_flushD = 1'b1;
                w_flushE = 1'b1;
            end else if (w_loadUse) begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_flushE = 1'b1;
            end else if (jump_d) begin
                w_flushD = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_waitCnt     <= 8'd0;
            r_memError    <= 1'b0;
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        r_waitCnt <= 8'd1;
                        r_state   <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        if (r_waitCnt == c_WAIT_LIMIT) begin
                            r_state    <= ST_ERROR;
                            r_memError <= 1'b1;
                        end else begin
                            r_waitCnt <= r_waitCnt + 8'd1;
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            // Counters freeze once trapped so they reflect pre-error activity.
            if (r_state != ST_ERROR) begin
                if (w_stallF && (r_stallCycles != '1)) begin
                    r_stallCycles <= r_stallCycles + c_CNT_ONE;
                end
                if ((w_flushD || w_flushE) && (r_flushEvents != '1)) begin
                    r_flushEvents <= r_flushEvents + c_CNT_ONE;
                end
            end
        end
    end

    assign stall_f      = w_stallF;
    assign stall_d      = w_stallD;
    assign stall_e      = w_stallE;
    assign stall_m      = w_stallM;
    assign flush_d      = w_flushD;
    assign flush_e      = w_flushE;
    assign fwd_a        = w_fwdA;
    assign fwd_b        = w_fwdB;
    assign state        = r_state;
    assign mem_error    = r_memError;
    assign stall_cycles = r_stallCycles;
    assign flush_events = r_flushEvents;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit (TIMEOUT=4, CNT_W=4).
//               A behavioural model tracks consecutive busy cycles, the error
//               trap and the counters; every cycle the DUT is compared to it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] rs1_d, rs2_d, rs1_e, rs2_e, wb_ex, wb_mem, wb_wb;
    logic uses_rs1_d, uses_rs2_d, write_reg_ex, write_reg_mem, write_reg_wb;
    logic load_ex, load_mem, branch_taken_ex, jump_d, mem_busy;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_error;
    logic [1:0] fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e),
        .wb_ex(wb_ex), .wb_mem(wb_mem), .wb_wb(wb_wb),
        .write_reg_ex(write_reg_ex), .write_reg_mem(write_reg_mem), .write_reg_wb(write_reg_wb),
        .load_ex(load_ex), .load_mem(load_mem),
        .branch_taken_ex(branch_taken_ex), .jump_d(jump_d), .mem_busy(mem_busy),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .state(state), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: length of the current run of busy cycles, trap flag, counts.
    int busyRun  = 0;
    bit trapped  = 0;
    int mStalls  = 0;
    int mFlushes = 0;

    logic eSF, eSD, eSE, eSM, eFD, eFE;
    logic [1:0] eFA, eFB;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] expFwd(input logic [2:0] src);
        if (write_reg_mem && wb_mem != 0 && wb_mem == src && !load_mem) return 2'd1;
        if (write_reg_wb && wb_wb != 0 && wb_wb == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic computeExp();
        bit lu;
        {eSF, eSD, eSE, eSM, eFD, eFE} = '0;
        eFA = 2'd0;
        eFB = 2'd0;
        if (!rst) begin
            lu = load_ex && write_reg_ex && wb_ex != 0 &&
                 ((uses_rs1_d && rs1_d == wb_ex) || (uses_rs2_d && rs2_d == wb_ex));
            eFA = expFwd(rs1_e);
            eFB = expFwd(rs2_e);
            if (trapped || mem_busy) {eSF, eSD, eSE, eSM} = 4'b1111;
            else if (branch_taken_ex) {eFD, eFE} = 2'b11;
            else if (lu) {eSF, eSD, eFE} = 3'b111;
            else if (jump_d) eFD = 1'b1;
        end
    endtask

    task automatic compareAll();
        int expState;
        computeExp();
        expState = trapped ? 2 : (busyRun > 0 ? 1 : 0);
        chk("stall_f", int'(stall_f), int'(eSF));
        chk("stall_d", int'(stall_d), int'(eSD));
        chk("stall_e", int'(stall_e), int'(eSE));
        chk("stall_m", int'(stall_m), int'(eSM));
        chk("flush_d", int'(flush_d), int'(eFD));
        chk("flush_e", int'(flush_e), int'(eFE));
        chk("fwd_a", int'(fwd_a), int'(eFA));
        chk("fwd_b", int'(fwd_b), int'(eFB));
        chk("state", int'(state), expState);
        chk("mem_error", int'(mem_error), int'(trapped));
        chk("stall_cycles", int'(stall_cycles), mStalls);
        chk("flush_events", int'(flush_events), mFlushes);
    endtask

    task automatic modelReset();
        busyRun  = 0;
        trapped  = 0;
        mStalls  = 0;
        mFlushes = 0;
    endtask

    // Advances the model across one rising edge using this cycle's inputs.
    task automatic modelEdge();
        computeExp();
        if (rst) begin
            modelReset();
        end else begin
            if (!trapped) begin
                if (eSF && mStalls < CNT_MAX) mStalls++;
                if ((eFD || eFE) && mFlushes < CNT_MAX) mFlushes++;
                if (mem_busy) begin
                    busyRun++;
                    if (busyRun >= TIMEOUT) trapped = 1;
                end else begin
                    busyRun = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic clearInputs();
        {rs1_d, rs2_d, rs1_e, rs2_e, wb_ex, wb_mem, wb_wb} = '0;
        {uses_rs1_d, uses_rs2_d, write_reg_ex, write_reg_mem, write_reg_wb} = '0;
        {load_ex, load_mem, branch_taken_ex, jump_d, mem_busy} = '0;
    endtask

    task automatic setLoadUse();
        load_ex = 1; write_reg_ex = 1; wb_ex = 3; rs1_d = 3; uses_rs1_d = 1;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        modelReset();
        tick();
        rst = 0;
    endtask

    initial begin
        clearInputs();
        // Reset gating: busy memory and a forwarding match must not leak out.
        mem_busy = 1; write_reg_mem = 1; wb_mem = 2; rs1_e = 2;
        #1;
        chk("rst_stall_f", int'(stall_f), 0);
        chk("rst_fwd_a", int'(fwd_a), 0);
        tick();
        doReset();

        // Load-use: one bubble, then clear.
        setLoadUse();
        #1;
        chk("lu_stall_f", int'(stall_f), 1);
        chk("lu_flush_e", int'(flush_e), 1);
        tick();
        clearInputs();
        load_mem = 1; write_reg_mem = 1; wb_mem = 3;
        #1;
        chk("lu_next_stall_f", int'(stall_f), 0);
        chk("lu_stall_cycles", int'(stall_cycles), 1);
        tick();

        // Forwarding priority on operand B.
        doReset();
        rs2_e = 5; wb_mem = 5; wb_wb = 5; write_reg_mem = 1; write_reg_wb = 1;
        #1;
        chk("fwd_b_mem", int'(fwd_b), 1);
        tick();
        load_mem = 1;
        #1;
        chk("fwd_b_wb", int'(fwd_b), 2);
        tick();
        rs2_e = 0; wb_mem = 0; wb_wb = 0;
        #1;
        chk("fwd_b_zero", int'(fwd_b), 0);
        tick();
        rs1_e = 4; wb_mem = 4; load_mem = 0; wb_wb = 4;
        tick();

        // Branch and load-use together: branch wins, one flush event.
        doReset();
        setLoadUse();
        branch_taken_ex = 1; jump_d = 1;
        #1;
        chk("br_flush_d", int'(flush_d), 1);
        chk("br_stall_f", int'(stall_f), 0);
        tick();
        clearInputs();
        jump_d = 1;
        #1;
        chk("br_flush_events", int'(flush_events), 1);
        tick();

        // Memory wait of three cycles, then zero-cycle release with a jump.
        doReset();
        mem_busy = 1;
        #1;
        chk("mw_state0", int'(state), 0);
        chk("mw_stall_m0", int'(stall_m), 1);
        tick();
        chk("mw_state1", int'(state), 1);
        tick();
        chk("mw_state2", int'(state), 1);
        tick();
        mem_busy = 0; jump_d = 1;
        #1;
        chk("mw_release_stall_f", int'(stall_f), 0);
        chk("mw_release_flush_d", int'(flush_d), 1);
        tick();
        jump_d = 0;
        chk("mw_back_run", int'(state), 0);
        tick();

        // Timeout: four busy cycles trap; ERROR survives mem_busy dropping.
        doReset();
        mem_busy = 1;
        repeat (TIMEOUT) tick();
        chk("to_state", int'(state), 2);
        chk("to_mem_error", int'(mem_error), 1);
        mem_busy = 0;
        setLoadUse();
        tick();
        tick();
        chk("to_sticky_state", int'(state), 2);
        chk("to_frozen_stalls", int'(stall_cycles), TIMEOUT);
        #2;
        rst = 1;
        modelReset();
        #1;
        chk("to_rst_state", int'(state), 0);
        chk("to_rst_mem_error", int'(mem_error), 0);
        chk("to_rst_stall_cycles", int'(stall_cycles), 0);
        chk("to_rst_stall_f", int'(stall_f), 0);
        tick();
        rst = 0;

        // Saturation: load-use held 20 cycles on a 4-bit counter.
        clearInputs();
        setLoadUse();
        repeat (20) tick();
        chk("sat_stall_cycles", int'(stall_cycles), 15);
        chk("sat_flush_events", int'(flush_events), 15);
        clearInputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
